pipe_stall_ctrl: RTL and testbench

Central pipeline sequencer for the 6-stage core (pc, if, id, ex, mem, wb). It merges stall requests from id (load-use), ex (multi-cycle madd/msub/div) and mem (bus wait) into the stall[5:0] vector consumed by every pipeline register, including the ex/mem register. It also sequences exception flushes and defers them until an in-flight memory access completes. A stall watchdog reports a pipeline hang.

---
 rtl/pipe_stall_ctrl_if.sv | 27 ++
 rtl/pipe_stall_ctrl.sv | 109 ++++++++++
 tb/tb_pipe_stall_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/pipe_stall_ctrl_if.sv
// Pipeline-control bundle between the core's stage logic (master) and the
// central stall/flush sequencer (slave).
interface pipe_stall_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             stallreq_id;
    logic             stallreq_ex;
    logic             stallreq_mem;
    logic             flush_req;
    logic [31:0]      flush_pc_i;
    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;
    logic             flush_pending;
    logic [CNT_W-1:0] stall_cnt;
    logic             timeout;

    modport master (
        output stallreq_id, stallreq_ex, stallreq_mem, flush_req, flush_pc_i,
        input  stall, flush, new_pc, flush_pending, stall_cnt, timeout
    );

    modport slave (
        input  stallreq_id, stallreq_ex, stallreq_mem, flush_req, flush_pc_i,
        output stall, flush, new_pc, flush_pending, stall_cnt, timeout
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the 6-stage core: merges stage stall
// requests, defers exception flushes behind bus waits, and watches for hangs.
module pipe_stall_ctrl #(
    parameter int MAX_STALL = 200,
    parameter int CNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    pipe_stall_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PEND  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_STALL);

    state_t           state_q;
    logic             flush_q;
    logic             pend_q;
    logic [31:0]      new_pc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             timeout_q;
    logic [5:0]       stall_vec;

    // Deeper stalls freeze every earlier stage as well; a flush cycle overrides all.
    always_comb begin
        stall_vec = 6'b000000;
        if (state_q != FLUSH) begin
            if (bus.stallreq_mem)      stall_vec = 6'b011111;
            else if (bus.stallreq_ex)  stall_vec = 6'b001111;
            else if (bus.stallreq_id)  stall_vec = 6'b000111;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            flush_q  <= 1'b0;
            pend_q   <= 1'b0;
            new_pc_q <= 32'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.flush_req) begin
                        new_pc_q <= bus.flush_pc_i;
                        if (bus.stallreq_mem) begin
                            state_q <= PEND;
                            flush_q <= 1'b0;
                            pend_q  <= 1'b1;
                        end else begin
                            state_q <= FLUSH;
                            flush_q <= 1'b1;
                            pend_q  <= 1'b0;
                        end
                    end else begin
                        flush_q <= 1'b0;
                        pend_q  <= 1'b0;
                    end
                end
                PEND: begin
                    // The memory access is allowed to finish before the flush is issued.
                    if (!bus.stallreq_mem) begin
                        state_q <= FLUSH;
                        flush_q <= 1'b1;
                        pend_q  <= 1'b0;
                    end
                end
                FLUSH: begin
                    state_q <= RUN;
                    flush_q <= 1'b0;
                    pend_q  <= 1'b0;
                end
                default: begin
                    state_q <= RUN;
                    flush_q <= 1'b0;
                    pend_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        cnt_d = '0;
        if (stall_vec != 6'b000000) begin
            cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (cnt_d == CNT_MAX) timeout_q <= 1'b1;
        end
    end

    assign bus.stall         = stall_vec;
    assign bus.flush         = flush_q;
    assign bus.flush_pending = pend_q;
    assign bus.new_pc        = new_pc_q;
    assign bus.stall_cnt     = cnt_q;
    assign bus.timeout       = timeout_q;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed and randomized checks of pipe_stall_ctrl against a cycle-level
// behavioural model of the stall/flush rules.
module tb_pipe_stall_ctrl;
    localparam int MAX_STALL = 4;
    localparam int CNT_W     = 3;
    localparam int SAT       = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_stall_ctrl #(.MAX_STALL(MAX_STALL), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total  = 0;
    int passed = 0;

    // Behavioural model: "a flush is happening this cycle", "a flush is waiting",
    // the remembered handler address, and the watchdog count/flag.
    bit          m_flush_now;
    bit          m_waiting;
    logic [31:0] m_pc;
    int          m_cnt;
    bit          m_timeout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h at t=%0t", tag, obs, exp, $time);
    endtask

    // One clock cycle: drive inputs after the falling edge, check, then let the edge happen.
    task automatic cycle(input bit r, input bit id, input bit ex, input bit mem,
                         input bit fr, input logic [31:0] pc);
        logic [5:0] exp_stall;
        int         depth;
        rst              = r;
        bus.stallreq_id  = id;
        bus.stallreq_ex  = ex;
        bus.stallreq_mem = mem;
        bus.flush_req    = fr;
        bus.flush_pc_i   = pc;
        #1;
        // Number of frozen stages counted from the pc end of the pipe.
        depth = m_flush_now ? 0 : mem ? 5 : ex ? 4 : id ? 3 : 0;
        exp_stall = 6'((1 << depth) - 1);
        chk("stall", 32'(bus.stall), 32'(exp_stall));
        chk("flush", 32'(bus.flush), 32'(m_flush_now));
        chk("flush_pending", 32'(bus.flush_pending), 32'(m_waiting));
        chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_cnt));
        chk("timeout", 32'(bus.timeout), 32'(m_timeout));
        if (m_flush_now) chk("new_pc", bus.new_pc, m_pc);
        $display("t=%0t rst=%0b id=%0b ex=%0b mem=%0b fr=%0b pc=%h | stall=%b flush=%0b pend=%0b new_pc=%h cnt=%0d to=%0b",
                 $time, r, id, ex, mem, fr, pc, bus.stall, bus.flush, bus.flush_pending,
                 bus.new_pc, bus.stall_cnt, bus.timeout);
        @(posedge clk);
        if (r) begin
            m_flush_now = 0; m_waiting = 0; m_pc = 32'd0; m_cnt = 0; m_timeout = 0;
        end else begin
            m_cnt = (exp_stall != 0) ? ((m_cnt == SAT) ? SAT : m_cnt + 1) : 0;
            if (m_cnt == MAX_STALL) m_timeout = 1;
            if (m_flush_now) begin
                m_flush_now = 0;
            end else if (m_waiting) begin
                if (!mem) begin m_waiting = 0; m_flush_now = 1; end
            end else if (fr) begin
                m_pc = pc;
                if (mem) m_waiting = 1; else m_flush_now = 1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        m_flush_now = 0; m_waiting = 0; m_pc = 32'd0; m_cnt = 0; m_timeout = 0;
        rst = 1'b1;
        bus.stallreq_id = 0; bus.stallreq_ex = 0; bus.stallreq_mem = 0;
        bus.flush_req = 0; bus.flush_pc_i = 32'd0;
        @(posedge clk);
        @(negedge clk);

        // reset with idle requests
        cycle(1, 0, 0, 0, 0, 32'd0);
        cycle(0, 0, 0, 0, 0, 32'd0);

        // stall priority
        cycle(0, 1, 0, 0, 0, 32'd0);
        cycle(0, 1, 1, 0, 0, 32'd0);
        cycle(0, 1, 1, 1, 0, 32'd0);
        cycle(0, 0, 0, 0, 0, 32'd0);

        // immediate flush
        cycle(0, 0, 0, 0, 1, 32'h0000_0140);
        cycle(0, 0, 0, 0, 0, 32'd0);
        cycle(0, 0, 0, 0, 0, 32'd0);

        // deferred flush: first address must win
        cycle(0, 0, 0, 1, 0, 32'd0);
        cycle(0, 0, 0, 1, 1, 32'h0000_0180);
        cycle(0, 0, 0, 1, 1, 32'h0000_0200);
        cycle(0, 0, 0, 1, 0, 32'd0);
        cycle(0, 0, 0, 1, 0, 32'd0);
        cycle(0, 0, 0, 0, 0, 32'd0);
        cycle(0, 0, 0, 0, 0, 32'd0);
        cycle(0, 0, 0, 0, 0, 32'd0);

        // requests arriving during the flush cycle are ignored
        cycle(0, 0, 1, 0, 1, 32'h0000_0300);
        cycle(0, 0, 1, 0, 1, 32'h0000_0344);
        cycle(0, 0, 1, 0, 0, 32'd0);
        cycle(0, 0, 0, 0, 0, 32'd0);

        // watchdog from a clean reset, running into saturation
        cycle(1, 0, 0, 0, 0, 32'd0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 1, 0, 0, 32'd0);
        cycle(0, 0, 0, 0, 0, 32'd0);
        cycle(0, 0, 0, 0, 0, 32'd0);

        // reset while a flush is pending discards it
        cycle(0, 0, 0, 1, 1, 32'h0000_0400);
        cycle(0, 0, 0, 1, 0, 32'd0);
        cycle(1, 0, 0, 1, 0, 32'd0);
        cycle(0, 0, 0, 1, 0, 32'd0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 32'd0);

        // flush_req in the cycle mem falls goes straight to FLUSH
        cycle(0, 0, 0, 1, 0, 32'd0);
        cycle(0, 0, 0, 0, 1, 32'h0000_0500);
        cycle(0, 0, 0, 0, 0, 32'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 79) == 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 5) == 0),
                  $urandom);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
